// File: rtl/ram_arb_ctrl_if.sv
// Client, clear-control and RAM-port bundle for ram_arb_ctrl.
// The slave modport is the controller's view; the master modport is the clients/RAM side.
interface ram_arb_ctrl_if #(
  parameter int unsigned DATASIZE = 18,
  parameter int unsigned ADDRSIZE = 8
);
  logic                c0_req, c1_req;
  logic                c0_wr, c1_wr;
  logic [ADDRSIZE-1:0] c0_addr, c1_addr;
  logic [DATASIZE-1:0] c0_wdata, c1_wdata;
  logic                c0_gnt, c1_gnt;
  logic                c0_rvalid, c1_rvalid;
  logic [DATASIZE-1:0] c0_rdata, c1_rdata;
  logic                clear_start, clear_busy, clear_done;
  logic                ram_wen, ram_ren;
  logic [ADDRSIZE-1:0] ram_addr;
  logic [DATASIZE-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  c0_req, c1_req, c0_wr, c1_wr, c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  clear_start, ram_rdata,
    output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
    output clear_busy, clear_done, ram_wen, ram_ren, ram_addr, ram_wdata
  );

  modport master (
    output c0_req, c1_req, c0_wr, c1_wr, c0_addr, c1_addr, c0_wdata, c1_wdata,
    output clear_start, ram_rdata,
    input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
    input  clear_busy, clear_done, ram_wen, ram_ren, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Two-client round-robin arbiter for a single-port RAM with read-return routing.
// Optional zero-fill clear engine compiled in with `define RAM_ARB_CTRL_CLEAR_EN.
module ram_arb_ctrl #(
  parameter int unsigned DATASIZE  = 18,
  parameter int unsigned ADDRSIZE  = 8,
  parameter int unsigned PIPELINED = 0
) (
  input logic           clk,
  input logic           res,
  ram_arb_ctrl_if.slave bus
);
  localparam int unsigned LAT = 1 + PIPELINED;

  logic           arb_en;
  logic           clr_wr;
  logic [ADDRSIZE-1:0] clr_addr;
  logic           grant;
  logic           pick_c1;
  logic           rd_grant;
  logic           favour_c1;
  logic [LAT-1:0] pipe_vld;
  logic [LAT-1:0] pipe_own;

`ifdef RAM_ARB_CTRL_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDRSIZE:0] LAST_ADDR = {1'b0, {ADDRSIZE{1'b1}}};

  state_t            state, state_nxt;
  logic [ADDRSIZE:0] cnt, cnt_nxt;
  logic              done_q, done_nxt;

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        if (bus.clear_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  // clear_start in IDLE pre-empts any client request in the same cycle
  assign arb_en         = (state == IDLE) && !bus.clear_start;
  assign clr_wr         = (state == CLEAR);
  assign clr_addr       = cnt[ADDRSIZE-1:0];
  assign bus.clear_busy = (state == CLEAR);
  assign bus.clear_done = done_q;
`else
  assign arb_en         = 1'b1;
  assign clr_wr         = 1'b0;
  assign clr_addr       = '0;
  assign bus.clear_busy = 1'b0;
  assign bus.clear_done = 1'b0;
`endif

  always_comb begin
    bus.c0_gnt    = 1'b0;
    bus.c1_gnt    = 1'b0;
    bus.ram_wen   = 1'b0;
    bus.ram_ren   = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    grant         = 1'b0;
    pick_c1       = 1'b0;
    rd_grant      = 1'b0;
    if (!res) begin
      if (clr_wr) begin
        bus.ram_wen  = 1'b1;
        bus.ram_addr = clr_addr;
      end else if (arb_en && (bus.c0_req || bus.c1_req)) begin
        grant   = 1'b1;
        pick_c1 = bus.c1_req && (!bus.c0_req || favour_c1);
        if (pick_c1) begin
          bus.c1_gnt    = 1'b1;
          bus.ram_wen   = bus.c1_wr;
          bus.ram_ren   = !bus.c1_wr;
          bus.ram_addr  = bus.c1_addr;
          bus.ram_wdata = bus.c1_wdata;
        end else begin
          bus.c0_gnt    = 1'b1;
          bus.ram_wen   = bus.c0_wr;
          bus.ram_ren   = !bus.c0_wr;
          bus.ram_addr  = bus.c0_addr;
          bus.ram_wdata = bus.c0_wdata;
        end
        rd_grant = bus.ram_ren;
      end
    end
  end

  // Owner/valid shift line matches the RAM read latency so data lands with its owner
  always_ff @(posedge clk) begin
    if (res) begin
      favour_c1 <= 1'b0;
      pipe_vld  <= '0;
      pipe_own  <= '0;
    end else begin
      if (grant) favour_c1 <= !pick_c1;
      pipe_vld[0] <= rd_grant;
      pipe_own[0] <= pick_c1;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign bus.c0_rvalid = pipe_vld[LAT-1] && !pipe_own[LAT-1];
  assign bus.c1_rvalid = pipe_vld[LAT-1] &&  pipe_own[LAT-1];
  assign bus.c0_rdata  = bus.c0_rvalid ? bus.ram_rdata : '0;
  assign bus.c1_rdata  = bus.c1_rvalid ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: PIPELINED=0 and PIPELINED=1 instances share stimulus, each
// with its own RAM and a transaction-level reference model (shadow memory + return queue).
module tb_ram_arb_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_ARB_CTRL_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          who;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic          c0_req = 1'b0, c1_req = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic          clear_start = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input int p, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (PIPELINED=%0d) @%0t: got 0x%0h expected 0x%0h", tag, p, $time, got, exp);
    end
  endtask

  for (genvar P = 0; P < 2; P++) begin : g_p
    ram_arb_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

    assign bus.c0_req      = c0_req;
    assign bus.c1_req      = c1_req;
    assign bus.c0_wr       = c0_wr;
    assign bus.c1_wr       = c1_wr;
    assign bus.c0_addr     = c0_addr;
    assign bus.c1_addr     = c1_addr;
    assign bus.c0_wdata    = c0_wdata;
    assign bus.c1_wdata    = c1_wdata;
    assign bus.clear_start = clear_start;

    ram_arb_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(P)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
    );

    // RAM with 1+P cycle read latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_s0 = '0, rd_s1 = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
      if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_ren) rd_s0 <= mem[bus.ram_addr];
      rd_s1 <= rd_s0;
    end
    assign bus.ram_rdata = (P == 0) ? rd_s0 : rd_s1;

    // Reference model
    logic [DW-1:0] shadow [DEPTH];
    rd_t pend [$];
    bit  m_clear = 1'b0, m_done = 1'b0;
    int  m_addr = 0, last_who = 1, cyc = 0;
    initial for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    always @(negedge clk) begin : model
      rd_t           r;
      bit            who, wr, v0, v1;
      logic [DW-1:0] d0, d1, wd;
      logic [AW-1:0] a;
      cyc++;
      if (res) begin
        check_eq("gnt0_rst", P, bus.c0_gnt, 0);
        check_eq("gnt1_rst", P, bus.c1_gnt, 0);
        check_eq("wen_rst",  P, bus.ram_wen, 0);
        check_eq("ren_rst",  P, bus.ram_ren, 0);
        pend.delete();
        m_clear = 1'b0; m_done = 1'b0; m_addr = 0; last_who = 1;
      end else begin
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
          r = pend.pop_front();
          if (r.who) begin v1 = 1'b1; d1 = r.data; end
          else       begin v0 = 1'b1; d0 = r.data; end
        end
        check_eq("rvalid0", P, bus.c0_rvalid, v0);
        check_eq("rvalid1", P, bus.c1_rvalid, v1);
        if (v0) check_eq("rdata0", P, bus.c0_rdata, d0);
        if (v1) check_eq("rdata1", P, bus.c1_rdata, d1);
        check_eq("clear_busy", P, bus.clear_busy, m_clear);
        check_eq("clear_done", P, bus.clear_done, m_done);
        m_done = 1'b0;
        if (m_clear) begin
          check_eq("clr_gnt0",  P, bus.c0_gnt, 0);
          check_eq("clr_gnt1",  P, bus.c1_gnt, 0);
          check_eq("clr_wen",   P, bus.ram_wen, 1);
          check_eq("clr_ren",   P, bus.ram_ren, 0);
          check_eq("clr_addr",  P, bus.ram_addr, m_addr);
          check_eq("clr_wdata", P, bus.ram_wdata, 0);
          shadow[m_addr] = '0;
          if (m_addr == DEPTH - 1) begin m_clear = 1'b0; m_done = 1'b1; end
          else m_addr++;
        end else if (CLR && clear_start) begin
          check_eq("start_gnt0", P, bus.c0_gnt, 0);
          check_eq("start_gnt1", P, bus.c1_gnt, 0);
          check_eq("start_wen",  P, bus.ram_wen, 0);
          check_eq("start_ren",  P, bus.ram_ren, 0);
          m_clear = 1'b1; m_addr = 0;
        end else if (c0_req || c1_req) begin
          who      = (c0_req && c1_req) ? (last_who == 0) : c1_req;
          last_who = who;
          wr = who ? c1_wr    : c0_wr;
          a  = who ? c1_addr  : c0_addr;
          wd = who ? c1_wdata : c0_wdata;
          check_eq("gnt0", P, bus.c0_gnt, !who);
          check_eq("gnt1", P, bus.c1_gnt, who);
          check_eq("wen",  P, bus.ram_wen, wr);
          check_eq("ren",  P, bus.ram_ren, !wr);
          check_eq("addr", P, bus.ram_addr, a);
          if (wr) begin
            check_eq("wdata", P, bus.ram_wdata, wd);
            shadow[a] = wd;
          end else begin
            pend.push_back('{cyc + 1 + P, who, shadow[a]});
          end
        end else begin
          check_eq("idle_gnt0", P, bus.c0_gnt, 0);
          check_eq("idle_gnt1", P, bus.c1_gnt, 0);
          check_eq("idle_wen",  P, bus.ram_wen, 0);
          check_eq("idle_ren",  P, bus.ram_ren, 0);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet();
    c0_req = 1'b0; c1_req = 1'b0; clear_start = 1'b0;
  endtask

  task automatic drive(input bit who, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin c1_req = 1'b1; c1_wr = wr; c1_addr = a; c1_wdata = d; end
    else     begin c0_req = 1'b1; c0_wr = wr; c0_addr = a; c0_wdata = d; end
  endtask

  task automatic access(input bit who, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(who, wr, a, d);
    cycles(1);
    quiet();
  endtask

  task automatic fill_ff();
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, AW'(i), 8'hFF);
  endtask

  initial begin
    res = 1'b1;
    cycles(3);
    res = 1'b0;

    // both clients contend for 4 cycles straight out of reset
    drive(1'b0, 1'b0, 4'd1, '0);
    drive(1'b1, 1'b0, 4'd2, '0);
    cycles(4);
    quiet();
    cycles(3);

    access(1'b0, 1'b1, 4'd3, 8'h5A);
    access(1'b0, 1'b0, 4'd3, '0);
    cycles(3);

    access(1'b1, 1'b1, 4'd5, 8'h11);
    access(1'b0, 1'b1, 4'd6, 8'h22);
    access(1'b1, 1'b0, 4'd5, '0);
    access(1'b0, 1'b0, 4'd6, '0);
    cycles(3);

    // full sweep with a c0 read of address 9 held until the sweep ends
    fill_ff();
    clear_start = 1'b1;
    drive(1'b0, 1'b0, 4'd9, '0);
    cycles(1);
    clear_start = 1'b0;
    cycles(CLR ? 17 : 0);
    quiet();
    cycles(3);
    access(1'b0, 1'b0, 4'd9, '0);
    cycles(3);

    // reset lands while the sweep is at address 7
    fill_ff();
    access(1'b1, 1'b0, 4'd2, '0);
    clear_start = 1'b1;
    cycles(1);
    clear_start = 1'b0;
    cycles(7);
    res = 1'b1;
    cycles(1);
    res = 1'b0;
    cycles(2);
    access(1'b0, 1'b0, 4'd8, '0);
    access(1'b1, 1'b0, 4'd0, '0);
    access(1'b0, 1'b0, 4'd7, '0);
    cycles(3);

    for (int i = 0; i < 300; i++) begin
      c0_req      = 1'($urandom_range(0, 1));
      c1_req      = 1'($urandom_range(0, 1));
      c0_wr       = 1'($urandom_range(0, 1));
      c1_wr       = 1'($urandom_range(0, 1));
      c0_addr     = AW'($urandom_range(0, DEPTH - 1));
      c1_addr     = AW'($urandom_range(0, DEPTH - 1));
      c0_wdata    = DW'($urandom);
      c1_wdata    = DW'($urandom);
      clear_start = ($urandom_range(0, 39) == 0);
      res         = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    res = 1'b0;
    quiet();
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arb_ctrl.md
RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 18: data word width.
REQ-002 SHALL have parameter ADDRSIZE, default 8: address width; the RAM depth is 2**ADDRSIZE.
REQ-003 SHALL have parameter PIPELINED, default 0: RAM read latency. 0 gives 1 cycle, 1 gives 2 cycles.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all logic on its rising edge.
  res  in  1  reset, synchronous, active-high.
  c0_req / c1_req  in  1  client request, held until granted.
  c0_wr / c1_wr  in  1  1 = write, 0 = read.
  c0_addr / c1_addr  in  ADDRSIZE  client address.
  c0_wdata / c1_wdata  in  DATASIZE  client write data.
  c0_gnt / c1_gnt  out  1  request accepted this cycle (combinational).
  c0_rvalid / c1_rvalid  out  1  read data valid, one-cycle pulse.
  c0_rdata / c1_rdata  out  DATASIZE  read data, valid only with rvalid.
  clear_start  in  1  pulse that starts the zero-fill of the whole RAM.
  clear_busy  out  1  clear sweep in progress.
  clear_done  out  1  one-cycle pulse after the last clear write.
  ram_wen  out  1  RAM port write enable.
  ram_ren  out  1  RAM port read enable.
  ram_addr  out  ADDRSIZE  RAM port address.
  ram_wdata  out  DATASIZE  RAM port write data.
  ram_rdata  in  DATASIZE  RAM port read data.

Function
REQ-005 SHALL issue at most one RAM access per cycle; ram_wen and ram_ren SHALL never both be 1.
REQ-006 In IDLE, a single requesting client SHALL be granted in the same cycle.
  - gnt=1; the RAM outputs carry that client's addr and wdata; ram_wen=wr; ram_ren=!wr.
REQ-007 When both clients request in IDLE, the client not granted most recently SHALL win; the priority pointer updates only on a grant.
REQ-008 A write SHALL produce no rvalid.
REQ-009 A granted read SHALL return c*_rdata=ram_rdata with c*_rvalid=1 exactly 1+PIPELINED cycles after the grant cycle.
  - Only the issuing client sees the pulse.
  - Routing uses a registered owner/valid shift pipeline of depth 1+PIPELINED.
REQ-010 Back-to-back reads, one per cycle and alternating clients, SHALL return in issue order with no loss.
REQ-011 FSM states SHALL be IDLE and CLEAR.
  - IDLE->CLEAR: clear_start=1 in IDLE.
  - CLEAR->IDLE: in the cycle after the write to address 2**ADDRSIZE-1.
REQ-012 In CLEAR, the block SHALL write zeros to every address, one per cycle, in order 0 .. 2**ADDRSIZE-1.
  - ram_wen=1, ram_wdata=0; a sweep takes exactly 2**ADDRSIZE cycles.
  - clear_busy=1 for the whole sweep.
  - Client gnt=0; client requests stay pending.
REQ-013 clear_done SHALL pulse for one cycle in the first IDLE cycle after a sweep; arbitration resumes in that same cycle.
REQ-014 clear_start SHALL be ignored while in CLEAR.
REQ-015 When clear_start and a client request occur in the same IDLE cycle, clear SHALL win and the request SHALL get no grant.
REQ-016 Reads granted before a clear starts SHALL still return their rvalid during CLEAR.
REQ-017 The sweep counter SHALL be ADDRSIZE+1 bits wide, so the terminal address is detected without wrap-around aliasing.

Reset
REQ-018 While res=1 at a clock edge, the block SHALL reset to:
  - FSM IDLE, sweep counter 0, priority pointer favouring c0, read pipeline emptied.
REQ-019 The reset values of all registered outputs SHALL be:
  - c*_rvalid=0, c*_rdata=0, clear_busy=0, clear_done=0.
REQ-020 While res=1, the combinational outputs SHALL be 0: ram_wen, ram_ren, c*_gnt.
REQ-021 A reset during CLEAR SHALL abort the sweep with no clear_done; in-flight reads are discarded.

Configuration
REQ-022 Macro RAM_ARB_CTRL_CLEAR_EN SHALL control the clear engine.
  - Defined: the clear engine (REQ-011..017) is compiled in.
  - Undefined: no CLEAR state and no counter; clear_start is ignored; clear_busy=0 and clear_done=0 always.

Verification
REQ-023 Bench parameters SHALL be DATASIZE=8, ADDRSIZE=4, run for both PIPELINED values. Each scenario below SHALL be covered.
  - c0 writes 0x5A to address 3, then reads address 3: c0_gnt=1 on each access; c0_rvalid appears 1 (PIPELINED=0) or 2 (PIPELINED=1) cycles later with c0_rdata=0x5A; c1_rvalid stays 0.
  - c0 and c1 hold req for 4 cycles: grants go c0,c1,c0,c1; never both gnt in one cycle.
  - c1 reads address 5 (data 0x11), then c0 reads address 6 (data 0x22) on consecutive cycles: c1 gets 0x11, then one cycle later c0 gets 0x22.
  - Fill the RAM with 0xFF, then pulse clear_start: clear_busy=1 for 16 cycles; writes of 0 go to addresses 0..15; clear_done pulses once; a c0 req held during the sweep is granted on the clear_done cycle; a later read of address 9 returns 0x00.
  - Assert res at sweep address 7: clear_busy=0 in the next cycle; no clear_done; address 8 still reads 0xFF.
  - Build with the macro undefined and pulse clear_start: no ram_wen, clear_busy=0, clients keep being granted.
